// File: rtl/rgmii_recv_if.sv
// Receive-side bundle between the RGMII sampling front end and the receive MAC path.
// crc_ok exists only when RGMII_RECV_CRC_EN is defined.
interface rgmii_recv_if;
  logic       speed_1Gbit;
  logic       rx_ctl_h;
  logic       rx_ctl_l;
  logic [3:0] rxd_h;
  logic [3:0] rxd_l;
  logic [7:0] data;
  logic       data_valid;
  logic       active;
  logic       frame_end;
  logic       frame_err;
`ifdef RGMII_RECV_CRC_EN
  logic       crc_ok;
`endif

  modport master (
    output speed_1Gbit, rx_ctl_h, rx_ctl_l, rxd_h, rxd_l,
`ifdef RGMII_RECV_CRC_EN
    input  crc_ok,
`endif
    input  data, data_valid, active, frame_end, frame_err
  );

  modport slave (
    input  speed_1Gbit, rx_ctl_h, rx_ctl_l, rxd_h, rxd_l,
`ifdef RGMII_RECV_CRC_EN
    output crc_ok,
`endif
    output data, data_valid, active, frame_end, frame_err
  );
endinterface

// File: rtl/rgmii_recv.sv
// RGMII receiver: strips preamble/SFD from demuxed DDR samples and emits payload bytes with frame flags.
// Optional FCS checking is compiled in with RGMII_RECV_CRC_EN.
module rgmii_recv #(
  parameter int MAX_PREAMB_BYTES = 15,
  parameter int MAX_FRAME_BYTES  = 1522
) (
  input logic         clock,
  input logic         reset_n,
  rgmii_recv_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_DISCARD} state_t;

  // Preamble counted in bytes (1G) or nibbles (10/100); nibble limit allows MAX full pairs.
  localparam int PRE_W = $clog2(2 * MAX_PREAMB_BYTES + 3);
  localparam logic [PRE_W-1:0] PRE_LIM_B = PRE_W'(MAX_PREAMB_BYTES);
  localparam logic [PRE_W-1:0] PRE_LIM_N = PRE_W'(2 * MAX_PREAMB_BYTES + 1);
  localparam logic [10:0]      FRAME_LIM = 11'(MAX_FRAME_BYTES);

  state_t           state_reg;
  logic             mode_reg;
  logic [PRE_W-1:0] pre_cnt_reg;
  logic [10:0]      byte_cnt_reg;
  logic             err_reg;
  logic             from_payload_reg;
  logic             nib_phase_reg;
  logic [3:0]       nib_lo_reg;
  logic [7:0]       data_reg;
  logic             data_valid_reg;
  logic             active_reg;
  logic             frame_end_reg;
  logic             frame_err_reg;

  logic             dv;
  logic             er;
  logic [7:0]       byte_sym;
  logic             mode_1g;
  logic             is_pre;
  logic             is_sfd;
  logic [PRE_W-1:0] pre_lim;
  logic [7:0]       pay_byte;
  logic             pay_strobe;
  logic             crc_bad;

  assign dv       = bus.rx_ctl_h;
  assign er       = bus.rx_ctl_h ^ bus.rx_ctl_l;
  assign byte_sym = {bus.rxd_l, bus.rxd_h};
  assign mode_1g  = (state_reg == ST_IDLE) ? bus.speed_1Gbit : mode_reg;
  assign is_pre   = mode_1g ? (byte_sym == 8'h55) : (bus.rxd_h == 4'h5);
  assign is_sfd   = mode_1g ? (byte_sym == 8'hD5) : (bus.rxd_h == 4'hD);
  assign pre_lim  = mode_reg ? PRE_LIM_B : PRE_LIM_N;
  assign pay_byte   = mode_reg ? byte_sym : {bus.rxd_h, nib_lo_reg};
  assign pay_strobe = dv && (mode_reg || nib_phase_reg);

`ifdef RGMII_RECV_CRC_EN
  logic [31:0] crc_reg;
  logic [31:0] crc_rev;
  logic        crc_ok_reg;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // The reflected register holds the bit-reversed form of the standard residue.
  for (genvar gi = 0; gi < 32; gi++) begin : g_crc_rev
    assign crc_rev[gi] = crc_reg[31-gi];
  end

  assign crc_bad    = (crc_rev != 32'hC704DD7B);
  assign bus.crc_ok = crc_ok_reg;
`else
  assign crc_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      mode_reg         <= 1'b0;
      pre_cnt_reg      <= '0;
      byte_cnt_reg     <= '0;
      err_reg          <= 1'b0;
      from_payload_reg <= 1'b0;
      nib_phase_reg    <= 1'b0;
      nib_lo_reg       <= '0;
      data_reg         <= '0;
      data_valid_reg   <= 1'b0;
      active_reg       <= 1'b0;
      frame_end_reg    <= 1'b0;
      frame_err_reg    <= 1'b0;
`ifdef RGMII_RECV_CRC_EN
      crc_reg          <= '0;
      crc_ok_reg       <= 1'b0;
`endif
    end else begin
      data_valid_reg <= 1'b0;
      frame_end_reg  <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef RGMII_RECV_CRC_EN
      crc_ok_reg     <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          active_reg       <= 1'b0;
          from_payload_reg <= 1'b0;
          byte_cnt_reg     <= '0;
          err_reg          <= 1'b0;
          nib_phase_reg    <= 1'b0;
          if (dv) begin
            mode_reg    <= bus.speed_1Gbit;
            pre_cnt_reg <= PRE_W'(1);
            state_reg   <= is_pre ? ST_PREAMBLE : ST_DISCARD;
          end
        end

        ST_PREAMBLE: begin
          if (!dv) begin
            state_reg <= ST_IDLE;
          end else if (is_pre) begin
            if (pre_cnt_reg >= pre_lim)
              state_reg <= ST_DISCARD;
            else
              pre_cnt_reg <= pre_cnt_reg + PRE_W'(1);
          end else if (is_sfd) begin
            state_reg <= ST_PAYLOAD;
`ifdef RGMII_RECV_CRC_EN
            crc_reg   <= 32'hFFFFFFFF;
`endif
          end else begin
            state_reg <= ST_DISCARD;
          end
        end

        ST_PAYLOAD: begin
          if (!dv) begin
            // Empty frames and a dangling nibble are both reported as errored frames.
            frame_end_reg <= 1'b1;
            frame_err_reg <= err_reg || (byte_cnt_reg == 11'd0) || nib_phase_reg || crc_bad;
`ifdef RGMII_RECV_CRC_EN
            crc_ok_reg    <= !crc_bad;
`endif
            state_reg     <= ST_IDLE;
          end else begin
            if (er)
              err_reg <= 1'b1;
            if (!mode_reg) begin
              nib_phase_reg <= !nib_phase_reg;
              nib_lo_reg    <= bus.rxd_h;
            end
            if (pay_strobe) begin
              if (byte_cnt_reg >= FRAME_LIM) begin
                err_reg          <= 1'b1;
                from_payload_reg <= 1'b1;
                state_reg        <= ST_DISCARD;
              end else begin
                data_reg       <= pay_byte;
                data_valid_reg <= 1'b1;
                active_reg     <= 1'b1;
                if (byte_cnt_reg != 11'h7FF)
                  byte_cnt_reg <= byte_cnt_reg + 11'd1;
`ifdef RGMII_RECV_CRC_EN
                crc_reg        <= crc_step(crc_reg, pay_byte);
`endif
              end
            end
          end
        end

        ST_DISCARD: begin
          if (!dv) begin
            state_reg     <= ST_IDLE;
            frame_end_reg <= from_payload_reg;
            frame_err_reg <= from_payload_reg;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.data       = data_reg;
  assign bus.data_valid = data_valid_reg;
  assign bus.active     = active_reg;
  assign bus.frame_end  = frame_end_reg;
  assign bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_rgmii_recv.sv
// Directed bench for rgmii_recv: per-cycle vector table plus multi-cycle frame sequences.
// The FCS sequence is compiled only when RGMII_RECV_CRC_EN is defined.
module tb_rgmii_recv;
  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  rgmii_recv_if rx_if();

  rgmii_recv dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (rx_if.slave)
  );

  always #5 clock = ~clock;

`ifdef RGMII_RECV_CRC_EN
  localparam logic CRC_ON = 1'b1;
`else
  localparam logic CRC_ON = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  // Frames without a real FCS fail the CRC check when it is compiled in.
  typedef struct {
    logic       dv;
    logic       ctl_l;
    logic [7:0] sym;
    logic       exp_dv;
    logic [7:0] exp_data;
    logic       exp_act;
    logic       exp_fe;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl [22];

  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         dv_cyc [$];
  int         fe_cnt = 0;
  int         fe_cyc = 0;
  logic       last_ferr = 1'b0;
  logic       last_crc_ok = 1'b0;

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (rx_if.data_valid === 1'b1) begin
      rx_q.push_back(rx_if.data);
      dv_cyc.push_back(cyc);
    end
    if (rx_if.frame_end === 1'b1) begin
      fe_cnt    = fe_cnt + 1;
      fe_cyc    = cyc;
      last_ferr = rx_if.frame_err;
`ifdef RGMII_RECV_CRC_EN
      last_crc_ok = rx_if.crc_ok;
`endif
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic drive(input logic dv, input logic ctl_l, input logic [7:0] sym);
    rx_if.rx_ctl_h = dv;
    rx_if.rx_ctl_l = ctl_l;
    rx_if.rxd_h    = sym[3:0];
    rx_if.rxd_l    = sym[7:4];
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    drive(1'b1, 1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic preamble_1g(input int n);
    repeat (n) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic clear_mon();
    rx_q.delete();
    dv_cyc.delete();
    fe_cnt    = 0;
    last_ferr = 1'b0;
    last_crc_ok = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {23'd0, rx_if.data, rx_if.data_valid},
          32'd0);
    check({name, "_flags"}, {29'd0, rx_if.active, rx_if.frame_end, rx_if.frame_err}, 32'd0);
  endtask

`ifdef RGMII_RECV_CRC_EN
  function automatic logic [31:0] crc32_model(input logic [7:0] bytes [$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (bytes[k]) begin
      c = c ^ {24'd0, bytes[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction
`endif

  initial begin
    tbl = '{
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hD5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hA1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 1'b0, 8'hB2, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hD5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0},
      '{1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, CRC_ON},
      '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hD5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'hD5, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h77, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0},
      '{1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}
    };

    rx_if.speed_1Gbit = 1'b1;
    reset_n = 1'b0;
    idle(3);
    check_outputs_zero("reset");
    reset_n = 1'b1;

    // Per-cycle vectors: error byte, back-to-back frames, empty frame, bad preamble.
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].dv, tbl[i].ctl_l, tbl[i].sym);
      check($sformatf("vec%0d_flags", i),
            {28'd0, rx_if.data_valid, rx_if.active, rx_if.frame_end, rx_if.frame_err},
            {28'd0, tbl[i].exp_dv, tbl[i].exp_act, tbl[i].exp_fe, tbl[i].exp_ferr});
      if (tbl[i].exp_dv)
        check($sformatf("vec%0d_data", i), {24'd0, rx_if.data}, {24'd0, tbl[i].exp_data});
      $display("vec %0d: dv=%b sym=%h -> data_valid=%b data=%h fe=%b ferr=%b", i, tbl[i].dv,
               tbl[i].sym, rx_if.data_valid, rx_if.data, rx_if.frame_end, rx_if.frame_err);
    end

    // 1G frame with 64 payload bytes 0x01..0x40.
    clear_mon();
    preamble_1g(7);
    for (int i = 1; i <= 64; i++) send_byte(8'(i));
    idle(3);
    check("g64_count", 32'(rx_q.size()), 32'd64);
    for (int i = 0; i < 64 && i < rx_q.size(); i++)
      check($sformatf("g64_byte%0d", i), {24'd0, rx_q[i]}, 32'(i + 1));
    check("g64_fe", 32'(fe_cnt), 32'd1);
    check("g64_ferr", {31'd0, last_ferr}, {31'd0, CRC_ON});
    $display("frame 1G-64: bytes=%0d frame_end=%0d frame_err=%b", rx_q.size(), fe_cnt, last_ferr);

    // 10/100 frame: 15 preamble nibbles, SFD, bytes 0x01 and 0x02.
    clear_mon();
    rx_if.speed_1Gbit = 1'b0;
    idle(1);
    repeat (15) send_byte(8'h05);
    send_byte(8'h0D);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00);
    idle(3);
    check("nib_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("nib_byte0", {24'd0, rx_q[0]}, 32'h01);
      check("nib_byte1", {24'd0, rx_q[1]}, 32'h02);
      check("nib_spacing", 32'(dv_cyc[1] - dv_cyc[0]), 32'd2);
      check("nib_fe_lat", 32'(fe_cyc - dv_cyc[1]), 32'd1);
    end
    check("nib_fe", 32'(fe_cnt), 32'd1);
    check("nib_ferr", {31'd0, last_ferr}, {31'd0, CRC_ON});
    $display("frame nibble: bytes=%0d frame_end=%0d frame_err=%b", rx_q.size(), fe_cnt, last_ferr);

    // Odd nibble count: dangling nibble dropped and flagged.
    clear_mon();
    repeat (7) send_byte(8'h05);
    send_byte(8'h0D);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
    idle(3);
    check("odd_count", 32'(rx_q.size()), 32'd1);
    check("odd_fe", 32'(fe_cnt), 32'd1);
    check("odd_ferr", {31'd0, last_ferr}, 32'd1);
    $display("frame odd-nibble: bytes=%0d frame_end=%0d frame_err=%b", rx_q.size(), fe_cnt, last_ferr);

    // Over-long preamble discarded silently, next frame intact.
    clear_mon();
    rx_if.speed_1Gbit = 1'b1;
    idle(1);
    preamble_1g(16);
    send_byte(8'hAA); send_byte(8'hBB);
    idle(1);
    preamble_1g(7);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    idle(3);
    check("pre16_count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3)
      check("pre16_bytes", {8'd0, rx_q[0], rx_q[1], rx_q[2]}, 32'h00112233);
    check("pre16_fe", 32'(fe_cnt), 32'd1);
    check("pre16_ferr", {31'd0, last_ferr}, {31'd0, CRC_ON});
    $display("frame long-preamble: bytes=%0d frame_end=%0d", rx_q.size(), fe_cnt);

    // 1600-byte payload truncated at 1522 bytes.
    clear_mon();
    preamble_1g(7);
    for (int i = 0; i < 1600; i++) send_byte(8'(i));
    idle(3);
    check("long_count", 32'(rx_q.size()), 32'd1522);
    if (rx_q.size() == 1522)
      check("long_last", {24'd0, rx_q[1521]}, 32'hF1);
    check("long_fe", 32'(fe_cnt), 32'd1);
    check("long_ferr", {31'd0, last_ferr}, 32'd1);
    $display("frame overlength: bytes=%0d frame_end=%0d frame_err=%b", rx_q.size(), fe_cnt, last_ferr);

    // Reset at byte 10 of a frame: outputs clear, no frame_end for the aborted frame.
    clear_mon();
    preamble_1g(7);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i));
    reset_n = 1'b0;
    send_byte(8'h1A);
    check_outputs_zero("midrst");
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h20 + i));
    idle(3);
    check("midrst_count", 32'(rx_q.size()), 32'd10);
    check("midrst_fe", 32'(fe_cnt), 32'd0);
    $display("frame reset-mid: bytes=%0d frame_end=%0d", rx_q.size(), fe_cnt);

`ifdef RGMII_RECV_CRC_EN
    begin
      logic [7:0]  pl [$];
      logic [31:0] fcs;
      for (int i = 0; i < 60; i++) pl.push_back(8'(i * 7 + 3));
      fcs = crc32_model(pl);
      for (int pass = 0; pass < 2; pass++) begin
        clear_mon();
        if (pass == 1) pl[5] = pl[5] ^ 8'h04;
        preamble_1g(7);
        foreach (pl[k]) send_byte(pl[k]);
        send_byte(fcs[7:0]); send_byte(fcs[15:8]); send_byte(fcs[23:16]); send_byte(fcs[31:24]);
        idle(3);
        check($sformatf("crc%0d_fe", pass), 32'(fe_cnt), 32'd1);
        check($sformatf("crc%0d_ok", pass), {31'd0, last_crc_ok}, (pass == 0) ? 32'd1 : 32'd0);
        check($sformatf("crc%0d_ferr", pass), {31'd0, last_ferr}, (pass == 0) ? 32'd0 : 32'd1);
        $display("frame crc pass %0d: crc_ok=%b frame_err=%b", pass, last_crc_ok, last_ferr);
      end
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
